tlut_sweep_ctrl: RTL and testbench
==================================

# tlut_sweep_ctrl

Sweep controller and result capture for the temporal-LUT multiplier array. It drives the shared ramp value `rng` and the `enable` input of the per-lane equality comparator stage, and addresses the LUT ROM with the same ramp. It then captures, per lane, the ROM output on the cycle that lane's registered comparator hit returns. Once the sweep has fully drained, it presents all lane results on a valid/ready output port.

## Interface
- `INPUT_WIDTH`, 8: ramp/operand width; sweep length is 2^INPUT_WIDTH values.
- `DIM_A`, 16: number of lanes; equals the comparator lane count.
- `OUT_WIDTH`, 16: LUT ROM data width per lane result.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `rng`  out  INPUT_WIDTH  ramp value; drives comparator `rng` and LUT ROM address.
- `cmp_en`  out  1  drives comparator `enable`.
- `cmp_hit`  in  DIM_A  registered comparator outputs (1-cycle latency from `rng`/`cmp_en`).
- `lut_q`  in  OUT_WIDTH  LUT ROM read data (1-cycle latency from address `rng`).
- `out_valid`  out  1  result bundle available.
- `out_ready`  in  1  consumer accepts the bundle.
- `out_data`  out  DIM_A*OUT_WIDTH  lane i at bits [i*OUT_WIDTH +: OUT_WIDTH].
- `out_miss`  out  DIM_A  lane i received no hit during the sweep.

## Operation
- FSM states:
  - IDLE: `start` → SWEEP. Lane registers clear to 0 and all `out_miss` bits set to 1 on that edge.
  - SWEEP: `rng` starts at 0 and increments by 1 every cycle; `cmp_en`=1. When `rng`=2^INPUT_WIDTH−1 → DRAIN; `rng` returns to 0 and `cmp_en` drops to 0.
  - DRAIN: one cycle → DONE.
  - DONE: `out_valid`=1. On `out_valid & out_ready` → IDLE.
- Capture qualifier `cap_en` is `cmp_en` delayed one cycle. It aligns with `cmp_hit` and `lut_q`, which both lag `rng` by one cycle.
- Per lane, at each edge with `cap_en & cmp_hit[i]`: lane register ← `lut_q`, and `out_miss[i]` ← 0.
- Multiple hits on one lane (operands changed mid-sweep): the last hit wins. This is not flagged.
- A lane with no hit keeps 0 data and `out_miss`=1.
- `cmp_hit` is ignored whenever `cap_en`=0, so stale hits from before the sweep are discarded.
- `start` is ignored in SWEEP, DRAIN and DONE, including the DONE cycle in which the transfer completes.
- No arithmetic on the data path. The ramp counter is INPUT_WIDTH bits; its terminal value is detected explicitly and the counter never wraps freely.

## Timing
- Reset values: state IDLE, `rng`=0, `cmp_en`=0, `cap_en`=0, `busy`=0, `out_valid`=0, `out_data`=0, `out_miss`=0.
- Reset asserted in any state, including mid-sweep or while `out_valid`=1, returns the block to reset values on the next edge. Any partial result is discarded.
- Ramp schedule: let edge 0 be the edge that samples `start`. `rng`=k is driven after edge k, for k=0..2^INPUT_WIDTH−1.
- Capture schedule: the hit for `rng`=k is captured at edge k+2.
- DRAIN is entered after edge 2^INPUT_WIDTH. `out_valid` rises after edge 2^INPUT_WIDTH+1, so latency from start to valid is 2^INPUT_WIDTH+1 edges (17 for INPUT_WIDTH=4).
- `out_data` and `out_miss` are stable while `out_valid`=1. `out_valid` holds until accepted.
- After a transfer, `out_valid` drops on the next edge. The earliest next `start` is sampled in the following IDLE cycle.
- `busy` is registered with the FSM state and covers SWEEP, DRAIN and DONE.

## Structure
- Shared package `tlut_pkg` holds:
  - the state enum `sweep_state_t` (IDLE, SWEEP, DRAIN, DONE);
  - the default width localparams;
  - the terminal-count helper constant.
- One sub-module, `tlut_lane_capture`, instantiated DIM_A times in a generate loop. Each instance holds one lane's data register and miss flag, with inputs clear, `cap_en`, hit and `lut_q`.
- Top level: FSM, ramp counter, `cap_en` delay flop, output handshake.

## Test plan
All scenarios use INPUT_WIDTH=4, DIM_A=4, OUT_WIDTH=8, a ROM model with `lut_q`=3×address registered, and a behavioural comparator model with 1-cycle latency.
- Operands {2,7,0,15}, `start` pulse, `out_ready`=1 → `out_valid` after 17 edges; data {6,21,0,45}; `out_miss`=0.
- Operands {5,5,5,5} → all lanes 15; verifies the simultaneous-hit path; `busy` high for exactly 17 cycles before valid.
- Comparator model forced to never hit lane 2 → lane 2 data 0 and `out_miss`=4'b0100; other lanes correct.
- Hold `out_ready`=0 for 10 cycles after valid, and pulse `start` during DONE → outputs stable, `start` ignored. The transfer takes exactly one beat when `out_ready` rises, then the block returns to IDLE.
- Assert `rst` at `rng`=9 mid-sweep → next edge `rng`=0, `cmp_en`=0, `busy`=0. A fresh `start` then gives a correct result with no residue from the aborted sweep.
- Lane 0 operand changes from 3 to 12 mid-sweep → lane 0 result 36 (last hit wins).

Source files
------------

// File: rtl/tlut_pkg.sv
// tlut_pkg: shared state type, default widths and ramp terminal-count helper
package tlut_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    localparam int DEF_INPUT_WIDTH = 8;
    localparam int DEF_DIM_A       = 16;
    localparam int DEF_OUT_WIDTH   = 16;

    function automatic int unsigned rng_last(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tlut_lane_capture.sv
// tlut_lane_capture: one lane's result register and miss flag
module tlut_lane_capture #(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 cap_en,
    input  logic                 hit,
    input  logic [OUT_WIDTH-1:0] lut_q,
    output logic [OUT_WIDTH-1:0] data,
    output logic                 miss
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            miss <= 1'b0;
        end else if (clear) begin
            data <= '0;
            miss <= 1'b1;
        end else if (cap_en && hit) begin
            data <= lut_q;
            miss <= 1'b0;
        end
    end

endmodule

// File: rtl/tlut_sweep_ctrl.sv
// tlut_sweep_ctrl: ramp sweep FSM driving the comparators and LUT ROM,
// per-lane result capture and valid/ready result handshake
module tlut_sweep_ctrl
    import tlut_pkg::*;
#(
    parameter int INPUT_WIDTH = DEF_INPUT_WIDTH,
    parameter int DIM_A       = DEF_DIM_A,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic [INPUT_WIDTH-1:0]     rng,
    output logic                       cmp_en,
    input  logic [DIM_A-1:0]           cmp_hit,
    input  logic [OUT_WIDTH-1:0]       lut_q,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIM_A*OUT_WIDTH-1:0] out_data,
    output logic [DIM_A-1:0]           out_miss
);

    localparam logic [INPUT_WIDTH-1:0] RNG_LAST = INPUT_WIDTH'(rng_last(INPUT_WIDTH));

    sweep_state_t state;
    logic         cap_en;
    logic         clear;

    always_comb clear = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rng       <= '0;
            cmp_en    <= 1'b0;
            cap_en    <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // hits and ROM data lag the ramp by one cycle, so the qualifier does too
            cap_en <= cmp_en;
            case (state)
                IDLE: if (start) begin
                    state  <= SWEEP;
                    rng    <= '0;
                    cmp_en <= 1'b1;
                    busy   <= 1'b1;
                end
                SWEEP: if (rng == RNG_LAST) begin
                    state  <= DRAIN;
                    rng    <= '0;
                    cmp_en <= 1'b0;
                end else begin
                    rng <= rng + 1'b1;
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < DIM_A; i++) begin : g_lane
        tlut_lane_capture #(.OUT_WIDTH(OUT_WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (clear),
            .cap_en (cap_en),
            .hit    (cmp_hit[i]),
            .lut_q  (lut_q),
            .data   (out_data[i*OUT_WIDTH +: OUT_WIDTH]),
            .miss   (out_miss[i])
        );
    end

endmodule

// File: tb/tb_tlut_sweep_ctrl.sv
// tb_tlut_sweep_ctrl: sweep controller with behavioural comparator and 3x ROM,
// expected bundles queued at start and compared when out_valid appears
module tb_tlut_sweep_ctrl;

    localparam int IW = 4;
    localparam int DA = 4;
    localparam int OW = 8;

    typedef struct packed {
        logic [DA*OW-1:0] data;
        logic [DA-1:0]    miss;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, start, out_ready;
    logic             busy, cmp_en, out_valid;
    logic [IW-1:0]    rng;
    logic [DA-1:0]    cmp_hit, out_miss, no_hit;
    logic [OW-1:0]    lut_q;
    logic [DA*OW-1:0] out_data;
    logic [IW-1:0]    op [DA];

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    tlut_sweep_ctrl #(.INPUT_WIDTH(IW), .DIM_A(DA), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .rng       (rng),
        .cmp_en    (cmp_en),
        .cmp_hit   (cmp_hit),
        .lut_q     (lut_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_miss  (out_miss)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        lut_q <= OW'(3 * int'(rng));
        for (int i = 0; i < DA; i++)
            cmp_hit[i] <= cmp_en && (rng == op[i]) && !no_hit[i];
    end

    function automatic exp_t model();
        exp_t e;
        for (int i = 0; i < DA; i++) begin
            e.data[i*OW +: OW] = no_hit[i] ? '0 : OW'(3 * int'(op[i]));
            e.miss[i]          = no_hit[i];
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int a, input int b, input int c, input int d);
        op[0] = IW'(a); op[1] = IW'(b); op[2] = IW'(c); op[3] = IW'(d);
    endtask

    task automatic kick(output int lat, output int bc);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 100) begin
            bc += int'(busy);
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; no_hit = '0;
        set_ops(0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        checks++;
        if ({busy, cmp_en, out_valid, rng, out_miss, out_data} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b cmp_en=%b valid=%b rng=%0d miss=%b data=%h, need all 0",
                     busy, cmp_en, out_valid, rng, out_miss, out_data);
        end
        step();
        checks++;
        if (busy !== 1'b0 || cmp_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b cmp_en=%b, need 0 0", busy, cmp_en);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        exp_t e;
        set_ops(2, 7, 0, 15);
        no_hit = '0;
        sb.push_back(model());
        out_ready = 1'b1;
        kick(lat, bc);
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, need 17", lat);
        end
        e = sb.pop_front();
        checks++;
        if (out_data !== e.data || out_miss !== e.miss) begin
            errors++;
            $display("FAIL basic_data: got %h/%b, need %h/%b", out_data, out_miss, e.data, e.miss);
        end
        checks++;
        if (out_data !== {8'd45, 8'd0, 8'd21, 8'd6}) begin
            errors++;
            $display("FAIL basic_const: got %h, need 2d001506", out_data);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: valid=%b busy=%b, need 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_same_operand();
        int lat, bc;
        exp_t e;
        set_ops(5, 5, 5, 5);
        sb.push_back(model());
        out_ready = 1'b1;
        kick(lat, bc);
        checks++;
        if (bc != 17 || lat != 17) begin
            errors++;
            $display("FAIL same_busy: busy cycles %0d latency %0d, need 17 17", bc, lat);
        end
        e = sb.pop_front();
        checks++;
        if (out_data !== e.data || out_miss !== e.miss) begin
            errors++;
            $display("FAIL same_data: got %h/%b, need %h/%b", out_data, out_miss, e.data, e.miss);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_miss();
        int lat, bc;
        exp_t e;
        set_ops(1, 2, 3, 4);
        no_hit = 4'b0100;
        sb.push_back(model());
        out_ready = 1'b1;
        kick(lat, bc);
        e = sb.pop_front();
        checks++;
        if (out_data !== e.data || out_miss !== 4'b0100) begin
            errors++;
            $display("FAIL miss_lane2: got %h/%b, need %h/0100", out_data, out_miss, e.data);
        end
        step();
        out_ready = 1'b0;
        no_hit = '0;
    endtask

    task automatic test_backpressure();
        int lat, bc, bad;
        exp_t e;
        set_ops(9, 10, 11, 12);
        sb.push_back(model());
        out_ready = 1'b0;
        kick(lat, bc);
        e = sb.pop_front();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 3);
            if (!out_valid || !busy || out_data !== e.data || out_miss !== e.miss) bad++;
            step();
        end
        start = 1'b0;
        checks++;
        if (bad != 0 || out_data !== e.data || !out_valid) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, data %h need %h", bad, out_data, e.data);
        end
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL one_beat: valid=%b busy=%b, need 0 0", out_valid, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0 || cmp_en !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: busy=%b cmp_en=%b, need 0 0", busy, cmp_en);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n, lat, bc;
        exp_t e;
        set_ops(1, 1, 1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (rng != 4'd9 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (rng !== 4'd9 || cmp_en !== 1'b1) begin
            errors++;
            $display("FAIL abort_reach: rng=%0d cmp_en=%b, need 9 1", rng, cmp_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rng !== '0 || cmp_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_miss !== '0) begin
            errors++;
            $display("FAIL abort_reset: rng=%0d cmp_en=%b busy=%b valid=%b miss=%b, need 0",
                     rng, cmp_en, busy, out_valid, out_miss);
        end
        step();
        set_ops(8, 9, 10, 11);
        no_hit = 4'b1000;
        sb.push_back(model());
        out_ready = 1'b1;
        kick(lat, bc);
        e = sb.pop_front();
        checks++;
        if (lat != 17 || out_data !== e.data || out_miss !== e.miss) begin
            errors++;
            $display("FAIL abort_fresh: lat %0d got %h/%b, need 17 %h/%b",
                     lat, out_data, out_miss, e.data, e.miss);
        end
        step();
        out_ready = 1'b0;
        no_hit = '0;
    endtask

    task automatic test_last_hit_wins();
        int n;
        exp_t e;
        set_ops(3, 1, 2, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (rng != 4'd6 && n < 50) begin
            step();
            n++;
        end
        op[0] = 4'd12;
        sb.push_back(model());
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (out_data !== e.data || out_miss !== e.miss || out_data[7:0] !== 8'd36) begin
            errors++;
            $display("FAIL last_hit: got %h/%b, need %h/%b (lane0 36)", out_data, out_miss, e.data, e.miss);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_operand();
        test_miss();
        test_backpressure();
        test_reset_mid_sweep();
        test_last_hit_wins();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
